// File: rtl/multi_dataflow_package.sv
// Shared types for the multi_dataflow output collector: FSM states and packed control/flag bundles.
// Widths follow COLL_CNT_WIDTH, the collector's default counter width.
package multi_dataflow_package;

  localparam int unsigned COLL_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } collector_state_t;

  typedef struct packed {
    logic                      clear;
    logic                      start;
    logic [COLL_CNT_WIDTH-1:0] len;
  } ctrl_collector_t;

  typedef struct packed {
    logic                      busy;
    logic                      done;
    logic [COLL_CNT_WIDTH-1:0] cnt;
    logic                      overflow;
  } flags_collector_t;

endpackage

// File: rtl/multi_dataflow_out_collector_if.sv
// Valid/ready stream bundle between the engine, the collector and the TCDM streamer.
// The master drives valid/data/strb and the slave drives ready; strb is unused on the slave side.
interface multi_dataflow_out_collector_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/multi_dataflow_out_fifo.sv
// Small power-of-two FIFO with read data presented combinationally from the head entry.
// Latency: a push is visible at pop_data_o the next cycle; a full FIFO refuses pushes.
module multi_dataflow_out_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           fill;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (fill == FULL_LVL);
  assign empty_o = (fill == '0);
  // A full FIFO refuses the push even when the same cycle frees a slot.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign pop_data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/multi_dataflow_out_collector.sv
// Buffers the engine output stream and forwards it, counting delivered beats against the job length.
// Latency: one cycle minimum through the FIFO; upstream ready depends only on registered state.
module multi_dataflow_out_collector
  import multi_dataflow_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = COLL_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   len_i,
  multi_dataflow_out_collector_if.slave  in_s,
  multi_dataflow_out_collector_if.master out_m,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   cnt_o,
  output logic                   overflow_o
);

  ctrl_collector_t  ctrl;
  flags_collector_t flags;
  collector_state_t state_q;
  collector_state_t state_d;

  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;
  logic                 flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 in_rdy;
  logic                 push;
  logic                 pop;
  logic                 start_acc;
  logic                 idle_or_done;

  assign ctrl.clear = clear_i;
  assign ctrl.start = start_i;
  assign ctrl.len   = len_i;

  assign flush        = rst_i | ctrl.clear;
  assign idle_or_done = (state_q == IDLE) | (state_q == DONE);
  assign start_acc    = (state_q == IDLE) & ctrl.start & (ctrl.len != '0);

  assign in_rdy = (state_q == RUN) & ~fifo_full & (acc_q < len_q);
  assign push   = in_s.valid & in_rdy;
  assign pop    = ~fifo_empty & out_m.ready & ((state_q == RUN) | (state_q == DRAIN));

  multi_dataflow_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (flush),
    .push_i      (push),
    .push_data_i (in_s.data),
    .pop_i       (pop),
    .pop_data_o  (out_m.data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl.start) state_d = (ctrl.len != '0) ? RUN : DONE;
      RUN:     if (acc_q == len_q) state_d = DRAIN;
      DRAIN:   if (fifo_empty && (cnt_q == len_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q <= IDLE;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        len_q <= ctrl.len;
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push) acc_q <= acc_q + 1'b1;
        if (pop)  cnt_q <= cnt_q + 1'b1;
        // Beats offered while no job is collecting are lost upstream; remember it.
        if (in_s.valid && !in_rdy && idle_or_done) ovf_q <= 1'b1;
      end
    end
  end

  assign flags.busy     = (state_q == RUN) | (state_q == DRAIN);
  assign flags.done     = (state_q == DONE);
  assign flags.cnt      = cnt_q;
  assign flags.overflow = ovf_q;

  assign in_s.ready  = in_rdy;
  assign out_m.valid = ~fifo_empty;
  assign out_m.strb  = '1;
  assign busy_o      = flags.busy;
  assign done_o      = flags.done;
  assign cnt_o       = flags.cnt;
  assign overflow_o  = flags.overflow;

endmodule

// File: tb/tb_multi_dataflow_out_collector.sv
// Bench for the output collector: queue scoreboard, table of jobs, and hand-written corner sequences.
module tb_multi_dataflow_out_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          start_i;
  logic [CW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] cnt_o;
  logic          overflow_o;

  multi_dataflow_out_collector_if #(.DATA_WIDTH(DW)) in_if ();
  multi_dataflow_out_collector_if #(.DATA_WIDTH(DW)) out_if ();

  multi_dataflow_out_collector #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .in_s       (in_if),
    .out_m      (out_if),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cnt_o      (cnt_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int len;
    int vpct;
    int rpct;
    int exp_cnt;
  } vec_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] nd;
  int            job_len, pushes, pops, done_seen, cyc, last_pop_cyc, done_cyc;
  bit            last_push;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set; samples, then advances one cycle.
  task automatic tick();
    logic [DW-1:0] exp_d;
    #1;
    last_push = 1'b0;
    if (in_if.ready === 1'b1) begin
      check("rdy_within_len", 64'(pushes < job_len), 64'd1);
      check("rdy_fifo_room", 64'((pushes - pops) < DEPTH), 64'd1);
    end
    if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      if (sb_q.size() == 0) check("pop_from_empty_model", 64'd1, 64'd0);
      else begin
        exp_d = sb_q.pop_front();
        check("pop_data", 64'(out_if.data), 64'(exp_d));
      end
      pops++;
      last_pop_cyc = cyc;
    end
    if (in_if.valid === 1'b1 && in_if.ready === 1'b1) begin
      sb_q.push_back(in_if.data);
      pushes++;
      nd = nd + 1;
      last_push = 1'b1;
    end
    if (done_o === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  // Upstream source: holds a beat until it is accepted, offers at most 'limit' accepted beats.
  task automatic drive_up(input int limit, input int vpct);
    if (last_push || in_if.valid !== 1'b1) begin
      in_if.valid = (pushes < limit) && ($urandom_range(0, 99) < vpct);
      in_if.data  = nd;
    end
  endtask

  task automatic begin_job(input int len);
    in_if.valid = 1'b0;
    start_i = 1'b1;
    len_i   = CW'(len);
    tick();
    start_i   = 1'b0;
    job_len   = len;
    pushes    = 0;
    pops      = 0;
    done_seen = 0;
    sb_q.delete();
  endtask

  task automatic finish_job(input int len, input int vpct, input int rpct, input int exp_cnt,
                            input int budget, input bit poke_start);
    int n = 0;
    while (done_seen == 0 && n < budget) begin
      drive_up(len, vpct);
      out_if.ready = ($urandom_range(0, 99) < rpct);
      start_i = poke_start && (n == 100);
      if (start_i) len_i = CW'(5);
      tick();
      start_i = 1'b0;
      n++;
    end
    if (done_seen == 0) check("job_timeout", 64'd1, 64'd0);
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    tick();
    tick();
    check("job_cnt", 64'(cnt_o), 64'(exp_cnt));
    check("job_done_pulses", 64'(done_seen), 64'd1);
    check("job_pops", 64'(pops), 64'(exp_cnt));
    check("job_model_empty", 64'(sb_q.size()), 64'd0);
    check("job_overflow", 64'(overflow_o), 64'd0);
    check("job_idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   s_cyc;
    bit   have;
    logic [DW-1:0] held;

    tbl[0] = '{len: 1,  vpct: 100, rpct: 100, exp_cnt: 1};
    tbl[1] = '{len: 5,  vpct: 100, rpct: 30,  exp_cnt: 5};
    tbl[2] = '{len: 16, vpct: 50,  rpct: 100, exp_cnt: 16};
    tbl[3] = '{len: 7,  vpct: 100, rpct: 100, exp_cnt: 7};
    tbl[4] = '{len: 9,  vpct: 30,  rpct: 60,  exp_cnt: 9};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.strb = '1; out_if.ready = 1'b0;
    nd = '0; job_len = 0; pushes = 0; pops = 0; done_seen = 0; cyc = 0;
    last_pop_cyc = 0; done_cyc = 0; last_push = 1'b0;

    // Reset state
    @(negedge clk_i);
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_in_ready", 64'(in_if.ready), 64'd0);
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_out_data", 64'(out_if.data), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("out_strb", 64'(out_if.strb), 64'hF);

    // Job flow: len 8, full rate, data 0..7
    nd = '0;
    s_cyc = cyc;
    begin_job(8);
    finish_job(8, 100, 100, 8, 60, 1'b0);
    check("flow_last_data_pushed", 64'(nd), 64'd8);
    check("flow_done_after_last_pop", 64'((done_cyc - last_pop_cyc) >= 1 && (done_cyc - last_pop_cyc) <= 2), 64'd1);
    check("flow_throughput", 64'((done_cyc - s_cyc) <= 12), 64'd1);

    // Backpressure: len 6, downstream stalled for 10 cycles
    nd = 32'h100;
    begin_job(6);
    out_if.ready = 1'b0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      if (out_if.valid === 1'b1) begin
        if (!have) begin
          have = 1'b1;
          held = out_if.data;
        end else check("bp_data_stable", 64'(out_if.data), 64'(held));
      end
      drive_up(6, 100);
      tick();
    end
    check("bp_pushes", 64'(pushes), 64'd4);
    check("bp_in_ready_low", 64'(in_if.ready), 64'd0);
    check("bp_head_data", 64'(out_if.data), 64'h100);
    finish_job(6, 100, 100, 6, 60, 1'b0);

    // Zero length
    begin_job(0);
    check("zl_done", 64'(done_o), 64'd1);
    check("zl_in_ready", 64'(in_if.ready), 64'd0);
    tick();
    check("zl_done_single", 64'(done_o), 64'd0);
    check("zl_busy", 64'(busy_o), 64'd0);

    // Extra beats: len 3, five beats offered
    nd = 32'h200;
    begin_job(3);
    out_if.ready = 1'b1;
    for (int i = 0; i < 40 && done_seen == 0; i++) begin
      if (busy_o === 1'b1) check("xb_no_ovf_busy", 64'(overflow_o), 64'd0);
      drive_up(5, 100);
      tick();
    end
    check("xb_done", 64'(done_seen), 64'd1);
    drive_up(5, 100);
    tick();
    check("xb_overflow", 64'(overflow_o), 64'd1);
    check("xb_pushes", 64'(pushes), 64'd3);
    check("xb_cnt", 64'(cnt_o), 64'd3);
    check("xb_in_ready", 64'(in_if.ready), 64'd0);
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    tick();

    // Table of jobs (first one also shows start clears the overflow flag)
    for (int i = 0; i < 5; i++) begin
      nd = DW'($urandom);
      begin_job(tbl[i].len);
      finish_job(tbl[i].len, tbl[i].vpct, tbl[i].rpct, tbl[i].exp_cnt, 400, 1'b0);
    end

    // Mid-job clear after 2 of 8 beats
    nd = 32'h300;
    begin_job(8);
    out_if.ready = 1'b1;
    drive_up(2, 100);
    tick();
    drive_up(2, 100);
    tick();
    check("mc_pre_valid", 64'(out_if.valid), 64'd1);
    check("mc_pre_cnt", 64'(cnt_o), 64'd1);
    clear_i = 1'b1;
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    tick();
    clear_i = 1'b0;
    sb_q.delete();
    job_len = 0;
    check("mc_out_valid", 64'(out_if.valid), 64'd0);
    check("mc_cnt", 64'(cnt_o), 64'd0);
    check("mc_busy", 64'(busy_o), 64'd0);
    check("mc_in_ready", 64'(in_if.ready), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("mc_no_done", 64'(done_seen), 64'd0);

    // Random stress with an ignored mid-job start
    nd = DW'($urandom);
    begin_job(1000);
    finish_job(1000, 60, 60, 1000, 20000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
